fpdiv_ctrl: RTL

- Control sequencer for the Goldschmidt fpdiv datapath.
- Generates en_a, en_b, en_rem, sel_mux3, sel_mux4 and rm from a start/done handshake, replacing the hand-timed control stimulus.
- Iteration count is parametrised per precision mode, selected per operation.
- Sits between the issue logic and fpdiv; its outputs wire straight to fpdiv's control ports.

---
 rtl/fpdiv_pkg.sv | 78 +++++++
 rtl/fpdiv_ctrl_if.sv | 34 +++
 rtl/fpdiv_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and encodings for the Goldschmidt fpdiv control sequencer.
// Optional abort input is enabled by defining FPDIV_CTRL_ABORT_EN.
package fpdiv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_N = 3'd1,
    INIT_D = 3'd2,
    ITER_A = 3'd3,
    ITER_B = 3'd4,
    REM    = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Multiplier factor select (sel_mux3)
  localparam logic [1:0] FAC_IA  = 2'b00;
  localparam logic [1:0] FAC_C   = 2'b01;
  localparam logic [1:0] FAC_REM = 2'b10;

  // Multiplicand select (sel_mux4)
  localparam logic [1:0] OP_NUM = 2'b00;
  localparam logic [1:0] OP_DEN = 2'b01;
  localparam logic [1:0] OP_A   = 2'b10;
  localparam logic [1:0] OP_B   = 2'b11;

  typedef struct packed {
    logic       en_a;
    logic       en_b;
    logic       en_rem;
    logic [1:0] sel_mux3;
    logic [1:0] sel_mux4;
    logic       busy;
    logic       done;
  } ctrl_t;

  function automatic ctrl_t decode_state(input state_t st);
    ctrl_t c;
    c.en_a     = 1'b0;
    c.en_b     = 1'b0;
    c.en_rem   = 1'b0;
    c.sel_mux3 = FAC_IA;
    c.sel_mux4 = OP_NUM;
    c.busy     = 1'b1;
    c.done     = 1'b0;
    case (st)
      INIT_N: begin
        c.en_a = 1'b1;
      end
      INIT_D: begin
        c.en_b     = 1'b1;
        c.sel_mux4 = OP_DEN;
      end
      ITER_A: begin
        c.en_a     = 1'b1;
        c.sel_mux3 = FAC_C;
        c.sel_mux4 = OP_A;
      end
      ITER_B: begin
        c.en_b     = 1'b1;
        c.sel_mux3 = FAC_C;
        c.sel_mux4 = OP_B;
      end
      REM: begin
        c.en_rem   = 1'b1;
        c.sel_mux3 = FAC_REM;
        c.sel_mux4 = OP_A;
      end
      DONE: begin
        c.done = 1'b1;
      end
      default: begin
        c.busy = 1'b0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fpdiv_ctrl_if.sv
// Issue-side handshake and fpdiv control bundle for fpdiv_ctrl.
// abort exists only when FPDIV_CTRL_ABORT_EN is defined.
interface fpdiv_ctrl_if;
  logic       start;
  logic       prec;
  logic       rm_in;
`ifdef FPDIV_CTRL_ABORT_EN
  logic       abort;
`endif
  logic       en_a;
  logic       en_b;
  logic       en_rem;
  logic [1:0] sel_mux3;
  logic [1:0] sel_mux4;
  logic       rm;
  logic       busy;
  logic       done;

  modport master (
`ifdef FPDIV_CTRL_ABORT_EN
    output abort,
`endif
    output start, prec, rm_in,
    input  en_a, en_b, en_rem, sel_mux3, sel_mux4, rm, busy, done
  );

  modport slave (
`ifdef FPDIV_CTRL_ABORT_EN
    input  abort,
`endif
    input  start, prec, rm_in,
    output en_a, en_b, en_rem, sel_mux3, sel_mux4, rm, busy, done
  );
endinterface

// File: rtl/fpdiv_ctrl.sv
// Control sequencer for the Goldschmidt fpdiv datapath: start/done handshake in,
// registered fpdiv control out. Define FPDIV_CTRL_ABORT_EN to add the abort input.
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int ITER_SP = 4,
  parameter int ITER_DP = 6,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  fpdiv_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] ITER_SP_C = CNT_W'(ITER_SP);
  localparam logic [CNT_W-1:0] ITER_DP_C = CNT_W'(ITER_DP);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  state_t           state_r;
  state_t           state_norm_s;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] n_r;
  logic [CNT_W-1:0] n_nxt_s;
  logic             rm_r;
  logic             rm_nxt_s;
  ctrl_t            out_r;

  // Normal sequencing; the counter only ever steps down to zero, never wraps
  always_comb begin
    state_norm_s = state_r;
    cnt_nxt_s    = cnt_r;
    n_nxt_s      = n_r;
    rm_nxt_s     = rm_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          n_nxt_s      = bus.prec ? ITER_DP_C : ITER_SP_C;
          rm_nxt_s     = bus.rm_in;
          state_norm_s = INIT_N;
        end else begin
          state_norm_s = IDLE;
        end
      end
      INIT_N: state_norm_s = INIT_D;
      INIT_D: begin
        if (n_r > CNT_ONE) begin
          cnt_nxt_s    = n_r - CNT_ONE;
          state_norm_s = ITER_A;
        end else begin
          cnt_nxt_s    = CNT_ZERO;
          state_norm_s = REM;
        end
      end
      ITER_A: state_norm_s = ITER_B;
      ITER_B: begin
        if (cnt_r > CNT_ONE) begin
          cnt_nxt_s    = cnt_r - CNT_ONE;
          state_norm_s = ITER_A;
        end else begin
          cnt_nxt_s    = CNT_ZERO;
          state_norm_s = REM;
        end
      end
      REM:     state_norm_s = DONE;
      DONE:    state_norm_s = IDLE;
      default: state_norm_s = IDLE;
    endcase
  end

  // Abort overrides the normal transition everywhere except IDLE
  always_comb begin
`ifdef FPDIV_CTRL_ABORT_EN
    if (bus.abort && (state_r != IDLE)) begin
      state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_norm_s;
    end
`else
    state_nxt_s = state_norm_s;
`endif
  end

  // State, counter, latched operands and outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      n_r     <= CNT_ZERO;
      rm_r    <= 1'b0;
      out_r   <= decode_state(IDLE);
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      n_r     <= n_nxt_s;
      rm_r    <= rm_nxt_s;
      out_r   <= decode_state(state_nxt_s);
    end
  end

  assign bus.en_a     = out_r.en_a;
  assign bus.en_b     = out_r.en_b;
  assign bus.en_rem   = out_r.en_rem;
  assign bus.sel_mux3 = out_r.sel_mux3;
  assign bus.sel_mux4 = out_r.sel_mux4;
  assign bus.busy     = out_r.busy;
  assign bus.done     = out_r.done;
  assign bus.rm       = rm_r;

endmodule
